xpt_phase_sequencer: RTL

//  Owns the XPT execution-phase register that drives every DECODER_I_* block. Advances XPT one

---
 rtl/xpt_phase_sequencer_pkg.sv | 26 ++
 rtl/xpt_phase_sequencer_slot_rotator.sv | 42 ++++
 rtl/xpt_phase_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xpt_phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// xpt_phase_sequencer_pkg
//  Shared definitions for the XPT phase sequencer:
//   - sequencer state encoding (2-bit enum)
//   - default widths / last legal phase
//   - one-hot PC write-slot encodings W0/W1/W2
// ---------------------------------------------------------------------------
package xpt_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int DEF_XPT_W    = 4;
    localparam int DEF_XPT_LAST = 15;
    localparam int DEF_CNT_W    = 8;

    // One-hot write slots, ordered {W2,W1,W0}
    localparam logic [2:0] SLOT_W0 = 3'b001;
    localparam logic [2:0] SLOT_W1 = 3'b010;
    localparam logic [2:0] SLOT_W2 = 3'b100;

endpackage

// File: rtl/xpt_phase_sequencer_slot_rotator.sv
// ---------------------------------------------------------------------------
// xpt_slot_rotator
//  3-bit one-hot ring that tracks XPT mod 3 as a PC write slot.
//  Ports:
//   clk     in   clock, rising edge
//   srst    in   synchronous active-high reset (ring -> W0)
//   i_load  in   reload ring to W0 (XPT restarting at 0)
//   i_adv   in   rotate one position left (100 wraps to 001)
//   o_slot  out  current one-hot slot {W2,W1,W0}
//  Reset/load take priority over advance; with neither asserted the ring holds.
// ---------------------------------------------------------------------------
module xpt_slot_rotator
    import xpt_phase_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [2:0] o_slot
);

    logic [2:0] r_slot;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ring
            // Each bit takes its value from its lower neighbour on advance,
            // bit 0 closing the ring from bit 2.
            localparam int PREV = (gi + 2) % 3;
            always_ff @(posedge clk) begin
                if (srst || i_load) begin
                    r_slot[gi] <= SLOT_W0[gi];
                end else if (i_adv) begin
                    r_slot[gi] <= r_slot[PREV];
                end
            end
        end
    endgenerate

    assign o_slot = r_slot;

endmodule

// File: rtl/xpt_phase_sequencer.sv
// ---------------------------------------------------------------------------
// xpt_phase_sequencer
//  Owns the XPT execution-phase register feeding the instruction decoders.
//  XPT advances one phase per clock in RUN, holds while memory is not ready,
//  restarts at 0 when a decoder flags the instruction's last phase, and
//  faults if it would advance past XPT_LAST. A 3-slot one-hot PC write
//  rotation is kept in step with XPT (slot = XPT mod 3).
//  Ports:
//   CLK           in   clock, all state on rising edge
//   RESET         in   synchronous active-high reset, overrides everything
//   start         in   leave IDLE, begin phase 0
//   Pa_Wait       in   memory not ready, hold current phase
//   PR_Reset_XPT  in   current phase is the instruction's last one
//   fault_clr     in   leave FAULT back to IDLE
//   XPT           out  current phase
//   notXPT        out  registered complement of XPT
//   decoder_en    out  high in RUN
//   pc_slot       out  one-hot write slot {W2,W1,W0}
//   instr_done    out  1-cycle pulse alongside the XPT restart to 0
//   instr_phases  out  phases used by the last completed instruction
//   seq_fault     out  high in FAULT
// ---------------------------------------------------------------------------
module xpt_phase_sequencer
    import xpt_phase_sequencer_pkg::*;
#(
    parameter int XPT_W    = DEF_XPT_W,
    parameter int XPT_LAST = DEF_XPT_LAST,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             Pa_Wait,
    input  logic             PR_Reset_XPT,
    input  logic             fault_clr,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic             decoder_en,
    output logic [2:0]       pc_slot,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_phases,
    output logic             seq_fault
);

    localparam logic [XPT_W-1:0] LAST_V = XPT_W'(XPT_LAST);

    state_t           r_state;
    state_t           w_state_next;
    logic [XPT_W-1:0] r_xpt;
    logic [XPT_W-1:0] w_xpt_next;
    logic [XPT_W-1:0] r_not_xpt;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_instr_phases;
    logic [CNT_W-1:0] w_phases_next;
    logic             r_instr_done;
    logic             w_done_next;
    logic             w_slot_load;
    logic             w_slot_adv;

    // Phase counter saturates rather than wrapping
    assign w_cnt_inc = (r_phase_cnt == {CNT_W{1'b1}}) ? r_phase_cnt
                                                      : r_phase_cnt + CNT_W'(1);

    always_comb begin
        w_state_next  = r_state;
        w_xpt_next    = r_xpt;
        w_cnt_next    = r_phase_cnt;
        w_phases_next = r_instr_phases;
        w_done_next   = 1'b0;
        w_slot_load   = 1'b0;
        w_slot_adv    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_xpt_next  = '0;
                w_slot_load = 1'b1;
                if (start) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            end
            ST_RUN: begin
                // Restart beats wait: a simultaneous Pa_Wait is seen again on phase 0
                if (PR_Reset_XPT) begin
                    w_xpt_next    = '0;
                    w_slot_load   = 1'b1;
                    w_done_next   = 1'b1;
                    w_phases_next = w_cnt_inc;
                    w_cnt_next    = '0;
                end else if (Pa_Wait) begin
                    w_state_next = ST_STALL;
                end else if (r_xpt == LAST_V) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_xpt_next = r_xpt + XPT_W'(1);
                    w_slot_adv = 1'b1;
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_STALL: begin
                // Decoders are disabled here, so PR_Reset_XPT is not honoured.
                // Returning to RUN re-presents the held phase.
                if (!Pa_Wait) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_next = ST_IDLE;
                    w_xpt_next   = '0;
                    w_slot_load  = 1'b1;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_xpt          <= '0;
            r_not_xpt      <= '1;
            r_phase_cnt    <= '0;
            r_instr_phases <= '0;
            r_instr_done   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_xpt          <= w_xpt_next;
            // Complement rail is its own flop so it switches with XPT, not after it
            r_not_xpt      <= ~w_xpt_next;
            r_phase_cnt    <= w_cnt_next;
            r_instr_phases <= w_phases_next;
            r_instr_done   <= w_done_next;
        end
    end

    xpt_slot_rotator u_slot_rotator (
        .clk    (CLK),
        .srst   (RESET),
        .i_load (w_slot_load),
        .i_adv  (w_slot_adv),
        .o_slot (pc_slot)
    );

    assign XPT          = r_xpt;
    assign notXPT       = r_not_xpt;
    assign decoder_en   = (r_state == ST_RUN);
    assign seq_fault    = (r_state == ST_FAULT);
    assign instr_done   = r_instr_done;
    assign instr_phases = r_instr_phases;

endmodule
